i2c_target_regfile: RTL and testbench
=====================================

Name: i2c_target_regfile

Overview:
- I2C target (responder) with an 8-bit register file, addressed by the team's I2C sensor-polling master.
- Emulates the temperature sensor for closed-loop simulation and FPGA self-test: the master FSM/FIFO/UART chain talks to it instead of a real device.
- Local logic preloads the "sensor" registers; bus writes are reported back to local logic.

Parameters:
- DEV_ADDR, 7'h27, 7-bit target address; 8-bit forms are 0x4E write, 0x4F read.
- NUM_REGS, 16, register count; power of two, 2..256.
- PTR_BITS, 4, log2(NUM_REGS).
- CFG_IDX, 3, index of the configuration register.
- CFG_RESET, 8'h00, reset value of reg[CFG_IDX]. All other registers reset to 8'h00.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  reset; asynchronous, active-high
- i_scl  in  1  SCL pad input (asynchronous)
- i_sda  in  1  SDA pad input (asynchronous)
- o_sda_oe  out  1  1 = pull SDA low; 0 = release. The pad ties output data to 0.
- o_busy  out  1  addressed transaction in progress
- i_upd_valid  in  1  local register write strobe
- i_upd_addr  in  PTR_BITS  local write index
- i_upd_data  in  8  local write data
- o_wr_valid  out  1  1-cycle pulse per data byte written over the bus
- o_wr_addr  out  PTR_BITS  index of the bus-written byte
- o_wr_data  out  8  value of the bus-written byte

Behaviour:
- Reset: o_sda_oe=0, o_busy=0, o_wr_valid=0, o_wr_addr=0, o_wr_data=0, pointer=0, state IDLE, registers at reset values.
- Reset applied mid-transfer releases SDA immediately (asynchronous).
- Input path: SCL and SDA each pass a 2-flop synchronizer plus a history flop. Edges are detected on the synchronized signals.
- Line timing: SCL high and low phases must each be at least 4 i_clk. o_sda_oe changes 1 cycle after a detected SCL fall, i.e. 3 i_clk after the pad edge.
- Bus conditions:
  - START: SDA fall while SCL high.
  - STOP: SDA rise while SCL high.
  - Both override bit logic in every state.
  - START/repeated START -> ADDR, bit count 0, SDA released.
  - STOP -> IDLE, SDA released, o_busy=0.
- Bit timing: the target samples on SCL rise and changes its SDA drive on SCL fall. Bytes are MSB first.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits.
    - Addr matches DEV_ADDR, R/W=0 -> ACK, then PTR.
    - Addr matches DEV_ADDR, R/W=1 -> ACK, then RDATA.
    - Mismatch -> IGNORE (no ACK, SDA never driven until the next START/STOP).
  - ACK phase: on the SCL fall after the 8th rise, o_sda_oe=1. On the SCL fall after the 9th rise, o_sda_oe=0. In a read, that same fall drives the data MSB instead.
  - PTR: 8 bits, always ACKed. pointer <= byte[PTR_BITS-1:0]; out-of-range flag set when byte >= NUM_REGS. Next state WDATA.
  - WDATA: 8 bits, always ACKed.
    - In range: reg[ptr] written and o_wr_valid pulses with ptr/data on the cycle of the 8th rise.
    - Out of range: byte dropped, no pulse.
    - Pointer then increments.
  - RDATA:
    - Shadow byte is loaded at the SCL fall ending the previous ACK: reg[ptr], or 8'hFF if out of range.
    - Each bit drives o_sda_oe = ~bit.
    - After 8 bits, release SDA for the master ACK bit and sample it on the 9th rise.
    - ACK (SDA=0) -> pointer++, continue RDATA.
    - NACK -> WAIT (released) until STOP/START.
- Pointer arithmetic:
  - Increments modulo NUM_REGS (NUM_REGS-1 wraps to 0).
  - Out-of-range flag clears on wrap.
  - Pointer persists across transactions, so a read without a PTR phase continues at the current pointer.
- Local update:
  - i_upd_valid writes reg[i_upd_addr] at any time.
  - Same cycle and index as a bus write: bus wins.
  - An update during an in-flight read byte does not alter the shadow byte.
- o_busy = 1 from address ACK through STOP or NACK-WAIT exit. It is 0 in IDLE and IGNORE.

Test Plan:
- START, 0x4E, 0x03, 0x04, STOP -> SDA low on all three 9th clocks; reg[3]=0x04; single o_wr_valid with addr=3, data=0x04; o_busy 0 after STOP.
- Local upd reg0=0x19, reg1=0x80; START, 0x4E, 0x00, Sr, 0x4F, read 2 bytes (master ACK then NACK), STOP -> bytes 0x19, 0x80; SDA released after NACK; pointer=2.
- START, 0x50, 0x00, STOP -> SDA high at 9th clock; o_sda_oe never 1; no o_wr_valid; registers unchanged.
- NUM_REGS=16: write ptr 0x0F, data 0xAA, 0xBB -> reg15=0xAA, reg0=0xBB; two pulses with addr 15 then 0.
- Ptr 0x20 then read 1 byte -> 0xFF returned; write ptr 0x20, data 0x55 -> ACKed, no o_wr_valid, registers unchanged.
- Assert i_rst while target drives an ACK low -> o_sda_oe=0 with no clock edge; after release, reg[3]=CFG_RESET and a fresh write transaction succeeds.

Source files
------------

// File: rtl/i2c_target_regfile.sv
// I2C target with a small byte-wide register file. It stands in for the
// temperature sensor polled by the I2C master, so the master chain can be
// exercised in simulation and in FPGA self-test without a real device.
// Local logic preloads registers; bytes written over the bus are echoed out.
//
// Handshake: o_wr_valid is a one-cycle pulse with o_wr_addr/o_wr_data valid in
// the same cycle and there is no back-pressure. i_upd_valid is a one-cycle
// write strobe that is always accepted. The bus-side flow control is the I2C
// ACK/NACK bit.
module i2c_target_regfile #(
    parameter logic [6:0] DEV_ADDR  = 7'h27,
    parameter int         NUM_REGS  = 16,
    parameter int         PTR_BITS  = 4,
    parameter int         CFG_IDX   = 3,
    parameter logic [7:0] CFG_RESET = 8'h00
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_scl,
    input  logic                i_sda,
    output logic                o_sda_oe,
    output logic                o_busy,
    input  logic                i_upd_valid,
    input  logic [PTR_BITS-1:0] i_upd_addr,
    input  logic [7:0]          i_upd_data,
    output logic                o_wr_valid,
    output logic [PTR_BITS-1:0] o_wr_addr,
    output logic [7:0]          o_wr_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_PTR,
        S_WDATA,
        S_RDATA,
        S_IGNORE,
        S_WAIT
    } state_t;

    state_t              state;
    logic [3:0]          bit_cnt;   // 0..7 data bits, 8 = after 8th rise, 9 = after 9th rise
    logic [6:0]          shreg;
    logic [PTR_BITS-1:0] ptr;
    logic                oor;       // pointer was loaded from an out-of-range byte
    logic                rw;
    logic                mack;      // master acknowledged the last read byte
    logic [7:0]          shadow;
    logic [7:0]          regs [NUM_REGS];

    logic scl_s1, scl_s2, scl_d;
    logic sda_s1, sda_s2, sda_d;

    logic                scl_rise, scl_fall;
    logic                start_cond, stop_cond;
    logic [7:0]          rx_byte;
    logic                byte_oor;
    logic [PTR_BITS-1:0] ptr_inc;
    logic                ptr_wrap;
    logic [7:0]          rd_byte;
    logic                bus_we;

    // Two-flop synchronizers plus a history flop; idle bus level is high.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            scl_s1 <= 1'b1;
            scl_s2 <= 1'b1;
            scl_d  <= 1'b1;
            sda_s1 <= 1'b1;
            sda_s2 <= 1'b1;
            sda_d  <= 1'b1;
        end else begin
            scl_s1 <= i_scl;
            scl_s2 <= scl_s1;
            scl_d  <= scl_s2;
            sda_s1 <= i_sda;
            sda_s2 <= sda_s1;
            sda_d  <= sda_s2;
        end
    end

    // Edge/condition decode and datapath helpers.
    always_comb begin
        scl_rise   = scl_s2 & ~scl_d;
        scl_fall   = ~scl_s2 & scl_d;
        start_cond = scl_s2 & scl_d & sda_d & ~sda_s2;
        stop_cond  = scl_s2 & scl_d & ~sda_d & sda_s2;
        rx_byte    = {shreg, sda_s2};
        byte_oor   = ({1'b0, rx_byte} >= 9'(NUM_REGS));
        ptr_inc    = ptr + PTR_BITS'(1);
        ptr_wrap   = (ptr == PTR_BITS'(NUM_REGS - 1));
        rd_byte    = oor ? 8'hFF : regs[ptr];
        bus_we     = scl_rise && (state == S_WDATA) && (bit_cnt == 4'd7) && !oor;
    end

    // Register file: local updates any time, a same-index bus write wins.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= (i == CFG_IDX) ? CFG_RESET : 8'h00;
            end
        end else begin
            if (i_upd_valid) regs[i_upd_addr] <= i_upd_data;
            if (bus_we)      regs[ptr] <= rx_byte;
        end
    end

    // Protocol FSM: samples on SCL rise, changes SDA drive on SCL fall.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= S_IDLE;
            bit_cnt    <= 4'd0;
            shreg      <= 7'd0;
            ptr        <= '0;
            oor        <= 1'b0;
            rw         <= 1'b0;
            mack       <= 1'b0;
            shadow     <= 8'h00;
            o_sda_oe   <= 1'b0;
            o_busy     <= 1'b0;
            o_wr_valid <= 1'b0;
            o_wr_addr  <= '0;
            o_wr_data  <= 8'h00;
        end else begin
            o_wr_valid <= 1'b0;
            if (start_cond) begin
                state    <= S_ADDR;
                bit_cnt  <= 4'd0;
                o_sda_oe <= 1'b0;
            end else if (stop_cond) begin
                state    <= S_IDLE;
                bit_cnt  <= 4'd0;
                o_sda_oe <= 1'b0;
                o_busy   <= 1'b0;
            end else begin
                case (state)
                    S_ADDR: begin
                        if (scl_rise) begin
                            if (bit_cnt < 4'd8) begin
                                shreg   <= rx_byte[6:0];
                                bit_cnt <= bit_cnt + 4'd1;
                                if (bit_cnt == 4'd7) begin
                                    rw <= rx_byte[0];
                                    if (rx_byte[7:1] != DEV_ADDR) begin
                                        state  <= S_IGNORE;
                                        o_busy <= 1'b0;
                                    end
                                end
                            end else begin
                                bit_cnt <= 4'd9;
                            end
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                o_sda_oe <= 1'b1;
                                o_busy   <= 1'b1;
                            end else if (bit_cnt == 4'd9) begin
                                bit_cnt <= 4'd0;
                                if (rw) begin
                                    state    <= S_RDATA;
                                    shadow   <= rd_byte;
                                    o_sda_oe <= ~rd_byte[7];
                                end else begin
                                    state    <= S_PTR;
                                    o_sda_oe <= 1'b0;
                                end
                            end
                        end
                    end
                    S_PTR, S_WDATA: begin
                        if (scl_rise) begin
                            if (bit_cnt < 4'd8) begin
                                shreg   <= rx_byte[6:0];
                                bit_cnt <= bit_cnt + 4'd1;
                                if (bit_cnt == 4'd7) begin
                                    if (state == S_PTR) begin
                                        ptr <= rx_byte[PTR_BITS-1:0];
                                        oor <= byte_oor;
                                    end else begin
                                        if (bus_we) begin
                                            o_wr_valid <= 1'b1;
                                            o_wr_addr  <= ptr;
                                            o_wr_data  <= rx_byte;
                                        end
                                        ptr <= ptr_inc;
                                        if (ptr_wrap) oor <= 1'b0;
                                    end
                                end
                            end else begin
                                bit_cnt <= 4'd9;
                            end
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                o_sda_oe <= 1'b1;
                            end else if (bit_cnt == 4'd9) begin
                                o_sda_oe <= 1'b0;
                                bit_cnt  <= 4'd0;
                                state    <= S_WDATA;
                            end
                        end
                    end
                    S_RDATA: begin
                        if (scl_rise) begin
                            if (bit_cnt < 4'd8) begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end else begin
                                // Pointer advances after every byte read out,
                                // acknowledged or not.
                                mack    <= ~sda_s2;
                                ptr     <= ptr_inc;
                                if (ptr_wrap) oor <= 1'b0;
                                bit_cnt <= 4'd9;
                            end
                        end else if (scl_fall) begin
                            if ((bit_cnt != 4'd0) && (bit_cnt < 4'd8)) begin
                                o_sda_oe <= ~shadow[3'd7 - bit_cnt[2:0]];
                            end else if (bit_cnt == 4'd8) begin
                                o_sda_oe <= 1'b0;
                            end else if (bit_cnt == 4'd9) begin
                                bit_cnt <= 4'd0;
                                if (mack) begin
                                    shadow   <= rd_byte;
                                    o_sda_oe <= ~rd_byte[7];
                                end else begin
                                    state    <= S_WAIT;
                                    o_sda_oe <= 1'b0;
                                end
                            end
                        end
                    end
                    default: begin
                        // IDLE, IGNORE and WAIT only react to START/STOP.
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Bench for i2c_target_regfile: a bit-banged open-drain I2C master drives
// directed transactions; acks, read bytes and write pulses are checked
// against hand-computed expectations held in queues.
module tb_i2c_target_regfile;

    logic       clk;
    logic       rst;
    logic       scl_m;
    logic       sda_m;
    logic       sda_line;
    logic       sda_oe;
    logic       busy;
    logic       upd_valid;
    logic [3:0] upd_addr;
    logic [7:0] upd_data;
    logic       wr_valid;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;

    int total = 0;
    int bad   = 0;
    logic oe_seen = 1'b0;

    logic [7:0]  exp_q[$];
    string       name_q[$];
    logic [7:0]  obs_q[$];
    logic [11:0] exp_wr_q[$];

    assign sda_line = sda_m & ~sda_oe;

    i2c_target_regfile dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_scl       (scl_m),
        .i_sda       (sda_line),
        .o_sda_oe    (sda_oe),
        .o_busy      (busy),
        .i_upd_valid (upd_valid),
        .i_upd_addr  (upd_addr),
        .i_upd_data  (upd_data),
        .o_wr_valid  (wr_valid),
        .o_wr_addr   (wr_addr),
        .o_wr_data   (wr_data)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [11:0] act, input logic [11:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: bus observations against expected queue, and write pulses.
    always @(negedge clk) begin
        if (sda_oe === 1'b1) oe_seen = 1'b1;
        if (wr_valid === 1'b1) begin
            total++;
            if (exp_wr_q.size() == 0) begin
                bad++;
                $display("FAIL wr_pulse: got addr=%h data=%h expected no pulse", wr_addr, wr_data);
            end else begin
                logic [11:0] e;
                e = exp_wr_q.pop_front();
                if ({wr_addr, wr_data} !== e) begin
                    bad++;
                    $display("FAIL wr_pulse: got %h expected %h", {wr_addr, wr_data}, e);
                end
            end
        end
        while (obs_q.size() > 0) begin
            logic [7:0] o;
            o = obs_q.pop_front();
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL bus_obs: got %h expected nothing", o);
            end else begin
                logic [7:0] e;
                string nm;
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if (o !== e) begin
                    bad++;
                    $display("FAIL %s: got %h expected %h", nm, o, e);
                end
            end
        end
    end

    // Driver tasks
    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1;
        wclk(2);
        scl_m = 1'b1;
        wclk(8);
        sda_m = 1'b0;
        wclk(8);
        scl_m = 1'b0;
        wclk(4);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0;
        wclk(4);
        scl_m = 1'b1;
        wclk(8);
        sda_m = 1'b1;
        wclk(8);
    endtask

    task automatic write_bit(input logic b);
        sda_m = b;
        wclk(4);
        scl_m = 1'b1;
        wclk(8);
        scl_m = 1'b0;
        wclk(4);
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1;
        wclk(4);
        scl_m = 1'b1;
        wclk(4);
        b = sda_line;
        wclk(4);
        scl_m = 1'b0;
        wclk(4);
    endtask

    // Send a byte; the ack level seen on the line is the observation.
    task automatic wb(input logic [7:0] d, input logic exp_ack, input string nm);
        logic a;
        exp_q.push_back({7'd0, exp_ack});
        name_q.push_back(nm);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(a);
        obs_q.push_back({7'd0, a});
    endtask

    // Receive a byte and answer with ACK (nack=0) or NACK (nack=1).
    task automatic rb(input logic [7:0] exp, input logic nack, input string nm);
        logic [7:0] d;
        logic b;
        exp_q.push_back(exp);
        name_q.push_back(nm);
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        obs_q.push_back(d);
        write_bit(nack);
    endtask

    task automatic upd(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        upd_valid = 1'b1;
        upd_addr  = a;
        upd_data  = d;
        @(negedge clk);
        upd_valid = 1'b0;
    endtask

    // Single-register read through a pointer write and repeated START.
    task automatic rd1(input logic [7:0] p, input logic [7:0] exp, input string nm);
        i2c_start();
        wb(8'h4E, 1'b0, "rd_addr_ack");
        wb(p, 1'b0, "rd_ptr_ack");
        i2c_start();
        wb(8'h4F, 1'b0, "rd_addr_r_ack");
        rb(exp, 1'b1, nm);
        i2c_stop();
    endtask

    initial begin
        rst       = 1'b1;
        scl_m     = 1'b1;
        sda_m     = 1'b1;
        upd_valid = 1'b0;
        upd_addr  = 4'd0;
        upd_data  = 8'd0;
        wclk(4);
        check("rst_oe", {11'd0, sda_oe}, 12'd0);
        check("rst_busy", {11'd0, busy}, 12'd0);
        check("rst_wr_valid", {11'd0, wr_valid}, 12'd0);
        check("rst_wr_addr", {8'd0, wr_addr}, 12'd0);
        check("rst_wr_data", {4'd0, wr_data}, 12'd0);
        rst = 1'b0;
        wclk(4);

        // Basic write of reg3
        exp_wr_q.push_back({4'd3, 8'h04});
        i2c_start();
        wb(8'h4E, 1'b0, "t1_addr_ack");
        check("t1_busy_on", {11'd0, busy}, 12'd1);
        wb(8'h03, 1'b0, "t1_ptr_ack");
        wb(8'h04, 1'b0, "t1_data_ack");
        i2c_stop();
        wclk(4);
        check("t1_busy_off", {11'd0, busy}, 12'd0);
        rd1(8'h03, 8'h04, "t1_reg3");

        // Local preload then burst read
        upd(4'd0, 8'h19);
        upd(4'd1, 8'h80);
        upd(4'd2, 8'h5A);
        i2c_start();
        wb(8'h4E, 1'b0, "t2_addr_ack");
        wb(8'h00, 1'b0, "t2_ptr_ack");
        i2c_start();
        wb(8'h4F, 1'b0, "t2_addr_r_ack");
        rb(8'h19, 1'b0, "t2_byte0");
        rb(8'h80, 1'b1, "t2_byte1");
        check("t2_oe_after_nack", {11'd0, sda_oe}, 12'd0);
        i2c_stop();
        // Read without a pointer phase continues at pointer 2
        i2c_start();
        wb(8'h4F, 1'b0, "t2_cont_addr_ack");
        rb(8'h5A, 1'b1, "t2_cont_byte");
        i2c_stop();

        // Wrong address is ignored
        oe_seen = 1'b0;
        i2c_start();
        wb(8'h50, 1'b1, "t3_addr_nack");
        check("t3_busy", {11'd0, busy}, 12'd0);
        wb(8'h00, 1'b1, "t3_data_nack");
        i2c_stop();
        check("t3_oe_never", {11'd0, oe_seen}, 12'd0);
        rd1(8'h00, 8'h19, "t3_reg0");

        // Pointer wrap during a write burst
        exp_wr_q.push_back({4'd15, 8'hAA});
        exp_wr_q.push_back({4'd0, 8'hBB});
        i2c_start();
        wb(8'h4E, 1'b0, "t4_addr_ack");
        wb(8'h0F, 1'b0, "t4_ptr_ack");
        wb(8'hAA, 1'b0, "t4_d0_ack");
        wb(8'hBB, 1'b0, "t4_d1_ack");
        i2c_stop();
        rd1(8'h0F, 8'hAA, "t4_reg15");
        rd1(8'h00, 8'hBB, "t4_reg0");

        // Out-of-range pointer
        rd1(8'h20, 8'hFF, "t5_oor_read");
        i2c_start();
        wb(8'h4E, 1'b0, "t5_addr_ack");
        wb(8'h20, 1'b0, "t5_ptr_ack");
        wb(8'h55, 1'b0, "t5_data_ack");
        i2c_stop();
        rd1(8'h00, 8'hBB, "t5_reg0");

        // Reset while the target holds the address ACK low
        i2c_start();
        for (int i = 7; i >= 0; i--) write_bit(logic'(8'h4E >> i));
        check("t6_oe_ack", {11'd0, sda_oe}, 12'd1);
        #3;
        rst = 1'b1;
        #1;
        check("t6_oe_async", {11'd0, sda_oe}, 12'd0);
        check("t6_busy_async", {11'd0, busy}, 12'd0);
        sda_m = 1'b1;
        scl_m = 1'b1;
        wclk(4);
        rst = 1'b0;
        wclk(4);
        rd1(8'h03, 8'h00, "t6_cfg_reset");
        exp_wr_q.push_back({4'd5, 8'h77});
        i2c_start();
        wb(8'h4E, 1'b0, "t6_addr_ack");
        wb(8'h05, 1'b0, "t6_ptr_ack");
        wb(8'h77, 1'b0, "t6_data_ack");
        i2c_stop();
        rd1(8'h05, 8'h77, "t6_reg5");

        wclk(20);
        check("exp_bus_drained", 12'(exp_q.size()), 12'd0);
        check("exp_wr_drained", 12'(exp_wr_q.size()), 12'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
